serial_add_sub: RTL and testbench

Parametrised multi-cycle adder/subtractor. Adds or subtracts two WIDTH-bit operands, processing DIGIT bits per clock through a chain of full-adder cells and a registered inter-digit carry. Sits beside the combinational full adders in the arithmetic library and serves area-constrained datapaths that can afford WIDTH/DIGIT cycles per operation. Uses a start/busy/done handshake and holds its result until the next operation.

---
 rtl/arith_pkg.sv | 16 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_add_sub.sv | 132 +++++++++++++
 tb/tb_serial_add_sub.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and helpers for the serial arithmetic blocks.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digits per operation; 0 flags a DIGIT that does not divide WIDTH.
  function automatic int calc_digits(input int width, input int digit);
    if (digit < 1 || (width % digit) != 0) return 0;
    return width / digit;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder, chained DIGIT times by serial_add_sub.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, result held from done
// until the next accepted start.
module serial_add_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = calc_digits(WIDTH, DIGIT);
  localparam int CW = $clog2(N) + 1;

  generate
    if (N == 0 || WIDTH < 2) begin : g_bad_cfg
      $error("serial_add_sub: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_s;
  logic [WIDTH-1:0] w_work_shift;
  logic             w_accept;
  logic             w_last;

  assign w_c[0] = r_carry;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
      fa_cell u_fa (
        .a    (r_a[gi]),
        .b    (r_b[gi]),
        .cin  (w_c[gi]),
        .sum  (w_s[gi]),
        .cout (w_c[gi+1])
      );
    end
  endgenerate

  // New digit enters at the MSB end; after N digits the word is aligned.
  assign w_work_shift = (r_work >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));
  assign w_last       = (r_cnt == CW'(N - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        // Subtraction is a + ~b + ~borrow_in.
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= cin ^ sub;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_work  <= w_work_shift;
        r_carry <= w_c[DIGIT];
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_result <= w_work_shift;
          r_cout   <= w_c[DIGIT];
          r_ovf    <= w_c[DIGIT] ^ w_c[DIGIT-1];
        end
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: directed cases on 8/1 and 8/4 plus
// random traffic on four WIDTH/DIGIT configurations.
`timescale 1ns/1ps
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_go = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: signed range test for overflow, unsigned borrow for cout.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin);
    logic [63:0] mask, ua, ub, res;
    longint sa, sb, v, hi, lo;
    logic co, ovf;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - longint'(64'd1 << w);
    if (ub[w-1]) sb = sb - longint'(64'd1 << w);
    v  = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
    hi = longint'(64'd1 << (w - 1)) - 1;
    lo = -(hi + 1);
    ovf = (v > hi) || (v < lo);
    if (sub) begin
      res = ua - ub - {63'd0, cin};
      co  = !(ua < (ub + {63'd0, cin}));
    end else begin
      res = ua + ub + {63'd0, cin};
      co  = res[w];
    end
    return {ovf, co, 32'(res & mask)};
  endfunction

  function automatic int cfg_w(input int i);
    case (i)
      0: return 8;
      1: return 8;
      2: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_d(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 8;
    endcase
  endfunction

  // Directed DUTs: 8/1 and 8/4 sharing one reset.
  logic       dir_rst_n;
  logic       d1_start, d1_sub, d1_cin, d1_busy, d1_done, d1_cout, d1_ovf;
  logic [7:0] d1_a, d1_b, d1_result;
  logic       d4_start, d4_sub, d4_cin, d4_busy, d4_done, d4_cout, d4_ovf;
  logic [7:0] d4_a, d4_b, d4_result;
  logic [33:0] d1_q[$];
  logic [33:0] d4_q[$];
  int d1_done_cnt = 0;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(dir_rst_n), .start(d1_start), .sub(d1_sub), .a(d1_a), .b(d1_b),
    .cin(d1_cin), .busy(d1_busy), .done(d1_done), .result(d1_result), .cout(d1_cout),
    .overflow(d1_ovf)
  );

  serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(dir_rst_n), .start(d4_start), .sub(d4_sub), .a(d4_a), .b(d4_b),
    .cin(d4_cin), .busy(d4_busy), .done(d4_done), .result(d4_result), .cout(d4_cout),
    .overflow(d4_ovf)
  );

  always @(negedge clk) begin
    if (d1_done) begin
      d1_done_cnt++;
      $display("[d1] done result=%h cout=%b ovf=%b", d1_result, d1_cout, d1_ovf);
      if (d1_q.size() == 0) check_eq("d1_spurious_done", 1, 0);
      else check_eq("d1_sb", {d1_ovf, d1_cout, 24'd0, d1_result}, d1_q.pop_front());
    end
    if (d4_done) begin
      $display("[d4] done result=%h cout=%b ovf=%b", d4_result, d4_cout, d4_ovf);
      if (d4_q.size() == 0) check_eq("d4_spurious_done", 1, 0);
      else check_eq("d4_sb", {d4_ovf, d4_cout, 24'd0, d4_result}, d4_q.pop_front());
    end
  end

  task automatic d1_go(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic cin, input bit push);
    d1_a = a; d1_b = b; d1_sub = sub; d1_cin = cin; d1_start = 1'b1;
    if (push) d1_q.push_back(model(8, {24'd0, a}, {24'd0, b}, sub, cin));
  endtask

  // Counts edges until done is seen; drops start after the first edge.
  task automatic d1_wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      d1_start = 1'b0;
    end while (!d1_done && n < 100);
  endtask

  // Random-traffic DUTs.
  logic rand_rst_n;
  bit   fin[4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rand
      localparam int W = cfg_w(gi);
      localparam int D = cfg_d(gi);
      logic         start, sub, cin, busy, done, cout, ovf;
      logic [W-1:0] a, b, result;
      logic [33:0]  q[$];

      serial_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk(clk), .rst_n(rand_rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy), .done(done), .result(result), .cout(cout),
        .overflow(ovf)
      );

      always @(negedge clk) begin
        if (done) begin
          $display("[cfg%0d] done result=%h cout=%b ovf=%b", gi, result, cout, ovf);
          if (q.size() == 0) check_eq($sformatf("cfg%0d_spurious_done", gi), 1, 0);
          else check_eq($sformatf("cfg%0d_sb", gi), {ovf, cout, 32'(result)}, q.pop_front());
        end
      end

      initial begin
        int n;
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        wait (rand_go);
        @(posedge clk); #1;
        for (int k = 0; k < 1000; k++) begin
          a   = W'($urandom);
          b   = W'($urandom);
          sub = 1'($urandom_range(0, 1));
          cin = 1'($urandom_range(0, 1));
          q.push_back(model(W, 32'(a), 32'(b), sub, cin));
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          n = 0;
          while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
          end
          check_eq($sformatf("cfg%0d_latency", gi), n, W / D);
          // Most ops start back-to-back from DONE; some leave an idle gap.
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        repeat (2) @(posedge clk);
        #1 check_eq($sformatf("cfg%0d_drain", gi), q.size(), 0);
        fin[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    dir_rst_n = 1'b0; rand_rst_n = 1'b0;
    d1_start = 0; d1_sub = 0; d1_cin = 0; d1_a = 0; d1_b = 0;
    d4_start = 0; d4_sub = 0; d4_cin = 0; d4_a = 0; d4_b = 0;
    repeat (2) @(posedge clk); #1;
    check_eq("reset_d1", {d1_busy, d1_done, d1_ovf, d1_cout, d1_result}, 0);
    check_eq("reset_d4", {d4_busy, d4_done, d4_ovf, d4_cout, d4_result}, 0);
    dir_rst_n = 1'b1; rand_rst_n = 1'b1;
    rand_go = 1'b1;
    @(posedge clk); #1;

    // 0x7F + 0x01: signed overflow, 9 cycles from the start edge.
    d1_go(8'h7F, 8'h01, 0, 0, 1);
    d1_wait_done(n);
    check_eq("add_7f_lat", n, 9);
    check_eq("add_7f", {d1_ovf, d1_cout, d1_result}, {1'b1, 1'b0, 8'h80});
    @(posedge clk); #1;

    d1_go(8'h05, 8'h07, 1, 0, 1);
    d1_wait_done(n);
    check_eq("sub_5_7", {d1_ovf, d1_cout, d1_result}, {1'b0, 1'b0, 8'hFE});
    @(posedge clk); #1;

    d1_go(8'h80, 8'h01, 1, 0, 1);
    d1_wait_done(n);
    check_eq("sub_80_1", {d1_ovf, d1_cout, d1_result}, {1'b1, 1'b1, 8'h7F});
    @(posedge clk); #1;

    // DIGIT=4: two digits, done 3 cycles after the start edge.
    d4_a = 8'hA5; d4_b = 8'h5A; d4_sub = 0; d4_cin = 1; d4_start = 1;
    d4_q.push_back(model(8, 32'hA5, 32'h5A, 0, 1));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      d4_start = 1'b0;
    end while (!d4_done && n < 100);
    check_eq("d4_lat", n, 3);
    check_eq("d4_add", {d4_ovf, d4_cout, d4_result}, {1'b0, 1'b1, 8'h00});
    @(posedge clk); #1;

    // start during RUN cycles 3-5 must be ignored; result must hold.
    d1_go(8'h12, 8'h34, 0, 0, 1);
    @(posedge clk); #1;
    d1_start = 1'b0;
    @(posedge clk); #1;
    d1_a = 8'hFF; d1_b = 8'hFF; d1_sub = 1'b1; d1_start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("run_hold", {d1_busy, d1_result}, {1'b1, 8'h7F});
    end
    d1_start = 1'b0;
    d1_wait_done(n);
    check_eq("ignore_lat", n + 5, 9);
    check_eq("ignore_res", d1_result, 8'h46);

    // start held during DONE: next op begins with no idle cycle.
    d1_go(8'h30, 8'h05, 1, 0, 1);
    @(posedge clk); #1;
    check_eq("b2b_busy", {d1_busy, d1_done}, 2'b10);
    d1_wait_done(n);
    check_eq("b2b_lat", n + 1, 9);
    check_eq("b2b_res", d1_result, 8'h2B);
    @(posedge clk); #1;

    // Reset in mid-RUN cycle 4 aborts with no done pulse.
    d1_go(8'h55, 8'h22, 0, 0, 0);
    @(posedge clk); #1;
    d1_start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    dir_rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_mid", {d1_busy, d1_done, d1_result}, 0);
    dir_rst_n = 1'b1;
    n = d1_done_cnt;
    repeat (12) @(posedge clk);
    #1 check_eq("rst_no_done", d1_done_cnt - n, 0);

    // Reset and start together: reset wins.
    dir_rst_n = 1'b0;
    d1_go(8'h01, 8'h01, 0, 0, 0);
    @(posedge clk); #1;
    check_eq("rst_wins", d1_busy, 0);
    d1_start = 1'b0;
    dir_rst_n = 1'b1;
    @(posedge clk); #1;

    d1_go(8'hFF, 8'h01, 0, 0, 1);
    d1_wait_done(n);
    check_eq("post_rst_lat", n, 9);
    check_eq("post_rst_res", {d1_ovf, d1_cout, d1_result}, {1'b0, 1'b1, 8'h00});
    @(posedge clk); #1;
    check_eq("d1_drain", d1_q.size(), 0);
    check_eq("d4_drain", d4_q.size(), 0);

    for (int t = 0; t < 30000 && !(fin[0] && fin[1] && fin[2] && fin[3]); t++)
      @(posedge clk);
    #1 check_eq("rand_complete", {fin[3], fin[2], fin[1], fin[0]}, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
